// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm scheduler and tone sources.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHIME  = 2'd1,
    ST_ALARM  = 2'd2,
    ST_SNOOZE = 2'd3
  } state_t;

  localparam int TONE_W    = 20;
  localparam int MEL_IDX_W = 5;

  // Buzzer periods in clock cycles for each note
  localparam logic [TONE_W-1:0] NOTE_A4   = 20'd113636;
  localparam logic [TONE_W-1:0] NOTE_G4   = 20'd127551;
  localparam logic [TONE_W-1:0] NOTE_F4   = 20'd143184;
  localparam logic [TONE_W-1:0] NOTE_E4   = 20'd151700;
  localparam logic [TONE_W-1:0] NOTE_D4   = 20'd170300;
  localparam logic [TONE_W-1:0] NOTE_C4   = 20'd191131;
  localparam logic [TONE_W-1:0] NOTE_BEEP = 20'd95556;
  localparam logic [TONE_W-1:0] REST      = '0;

  // Hourly beep count: 12-hour dial, midnight/noon sound twelve
  function automatic logic [3:0] chime_count(input logic [5:0] hr);
    logic [5:0] m;
    m = hr % 6'd12;
    if (m == 6'd0) return 4'd12;
    return m[3:0];
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational melody table: note index to buzzer period, REST past the end.
module melody_rom
  import alarm_pkg::*;
(
  input  logic [MEL_IDX_W-1:0] idx,
  output logic [TONE_W-1:0]    period
);

  always_comb begin
    period = REST;
    case (idx)
      5'd0:  period = NOTE_C4;
      5'd1:  period = NOTE_C4;
      5'd2:  period = NOTE_G4;
      5'd3:  period = NOTE_G4;
      5'd4:  period = NOTE_A4;
      5'd5:  period = NOTE_A4;
      5'd6:  period = NOTE_G4;
      5'd7:  period = NOTE_F4;
      5'd8:  period = NOTE_F4;
      5'd9:  period = NOTE_E4;
      5'd10: period = NOTE_E4;
      5'd11: period = NOTE_D4;
      5'd12: period = NOTE_D4;
      5'd13: period = NOTE_C4;
      5'd14: period = NOTE_G4;
      5'd15: period = NOTE_G4;
      5'd16: period = NOTE_F4;
      5'd17: period = NOTE_F4;
      5'd18: period = NOTE_E4;
      default: period = REST;
    endcase
  end

endmodule

// File: rtl/alarm_sched.sv
// Alarm clock scheduler: hourly chime, melody alarm and optional snooze.
// Define ALARM_SNOOZE_EN at build time to enable the snooze feature.
module alarm_sched
  import alarm_pkg::*;
#(
  parameter int MEL_LEN     = 19,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic [5:0]  hour,
  input  logic [5:0]  min,
  input  logic [5:0]  sec,
  input  logic [5:0]  alhour,
  input  logic [5:0]  almin,
  input  logic        al_en,
  input  logic        stop_key,
  input  logic        snooze_key,
  output logic [19:0] tone,
  output logic        ring_on,
  output logic [1:0]  state_o
);

  localparam int RING_W = $clog2(RING_SECS + 1);

  state_t                state, state_nxt;
  logic [MEL_IDX_W-1:0]  note_idx, idx_nxt;
  logic [RING_W-1:0]     ring_cnt, ring_nxt;
  logic [3:0]            beeps_left, beeps_nxt;
  logic                  beep_ph, ph_nxt;
  logic [TONE_W-1:0]     mel_period, tone_nxt;
  logic                  ring_on_nxt;
  logic                  alarm_hit, chime_hit;

  assign alarm_hit = tick_1hz && al_en && (hour == alhour) && (min == almin) && (sec == 6'd0);
  assign chime_hit = tick_1hz && (min == 6'd0) && (sec == 6'd0);

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_SECS + 1);
  logic [SNZ_W-1:0] snz_cnt, snz_nxt;
`else
  logic snooze_unused;
  assign snooze_unused = snooze_key | (SNOOZE_SECS == 0);
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = note_idx;
    ring_nxt  = ring_cnt;
    beeps_nxt = beeps_left;
    ph_nxt    = beep_ph;
`ifdef ALARM_SNOOZE_EN
    snz_nxt   = snz_cnt;
`endif
    if (stop_key || (!al_en && (state == ST_ALARM || state == ST_SNOOZE))) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      ring_nxt  = '0;
      beeps_nxt = '0;
      ph_nxt    = 1'b0;
    end else if (alarm_hit && state != ST_ALARM) begin
      state_nxt = ST_ALARM;
      idx_nxt   = '0;
      ring_nxt  = '0;
      beeps_nxt = '0;
      ph_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (chime_hit) begin
            state_nxt = ST_CHIME;
            beeps_nxt = chime_count(hour);
            ph_nxt    = 1'b1;
          end
        end
        // beep_ph high = beep sounding; the silent phase decides exit or next beep
        ST_CHIME: begin
          if (tick_1hz) begin
            if (beep_ph) begin
              ph_nxt = 1'b0;
            end else if (beeps_left <= 4'd1) begin
              state_nxt = ST_IDLE;
              beeps_nxt = '0;
            end else begin
              beeps_nxt = beeps_left - 4'd1;
              ph_nxt    = 1'b1;
            end
          end
        end
        ST_ALARM: begin
`ifdef ALARM_SNOOZE_EN
          if (snooze_key) begin
            state_nxt = ST_SNOOZE;
            snz_nxt   = '0;
          end else
`endif
          if (tick_1hz) begin
            if (ring_cnt == RING_W'(RING_SECS - 1)) begin
              state_nxt = ST_IDLE;
              idx_nxt   = '0;
              ring_nxt  = '0;
            end else begin
              idx_nxt  = (note_idx == MEL_IDX_W'(MEL_LEN - 1)) ? '0 : note_idx + MEL_IDX_W'(1);
              ring_nxt = ring_cnt + RING_W'(1);
            end
          end
        end
        ST_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
          if (tick_1hz) begin
            if (snz_cnt == SNZ_W'(SNOOZE_SECS - 1)) begin
              state_nxt = ST_ALARM;
              idx_nxt   = '0;
              ring_nxt  = '0;
              snz_nxt   = '0;
            end else begin
              snz_nxt = snz_cnt + SNZ_W'(1);
            end
          end
`else
          state_nxt = ST_IDLE;
`endif
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  melody_rom u_rom (
    .idx    (idx_nxt),
    .period (mel_period)
  );

  // Outputs are computed from the next state so they update with the state register
  always_comb begin
    tone_nxt    = REST;
    ring_on_nxt = 1'b0;
    case (state_nxt)
      ST_ALARM: begin
        tone_nxt    = mel_period;
        ring_on_nxt = 1'b1;
      end
      ST_CHIME: begin
        tone_nxt    = ph_nxt ? NOTE_BEEP : REST;
        ring_on_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      note_idx   <= '0;
      ring_cnt   <= '0;
      beeps_left <= '0;
      beep_ph    <= 1'b0;
      tone       <= '0;
      ring_on    <= 1'b0;
    end else begin
      state      <= state_nxt;
      note_idx   <= idx_nxt;
      ring_cnt   <= ring_nxt;
      beeps_left <= beeps_nxt;
      beep_ph    <= ph_nxt;
      tone       <= tone_nxt;
      ring_on    <= ring_on_nxt;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) snz_cnt <= '0;
    else        snz_cnt <= snz_nxt;
  end
`endif

  assign state_o = state;

endmodule

// File: tb/tb_alarm_sched.sv
// Scoreboard bench for alarm_sched; snooze checks follow ALARM_SNOOZE_EN.
module tb_alarm_sched;

  localparam logic [1:0] S_IDLE = 2'd0, S_CHIME = 2'd1, S_ALARM = 2'd2, S_SNOOZE = 2'd3;
  localparam int BEEP = 95556;

  typedef struct {
    logic [1:0]  st;
    logic [19:0] tone;
    logic        ring;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1hz = 1'b0;
  logic [5:0]  hour = '0, min = '0, sec = '0;
  logic [5:0]  alhour = '0, almin = '0;
  logic        al_en = 1'b0;
  logic        stop_key = 1'b0, snooze_key = 1'b0;
  logic [19:0] tone;
  logic        ring_on;
  logic [1:0]  state_o;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  int   mel[19] = '{191131, 191131, 127551, 127551, 113636, 113636, 127551, 143184, 143184,
                    151700, 151700, 170300, 170300, 191131, 127551, 127551, 143184, 143184,
                    151700};

  alarm_sched #(
    .MEL_LEN     (19),
    .RING_SECS   (60),
    .SNOOZE_SECS (300)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .alhour     (alhour),
    .almin      (almin),
    .al_en      (al_en),
    .stop_key   (stop_key),
    .snooze_key (snooze_key),
    .tone       (tone),
    .ring_on    (ring_on),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One clock with the given stimulus; expectation pushed before the edge, popped after it
  task automatic cyc(input logic tk, input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                     input logic stp, input logic snz, input logic [1:0] es, input int et,
                     input string tag);
    exp_t e;
    exp_q.push_back('{st: es, tone: 20'(et), ring: (es == S_CHIME || es == S_ALARM)});
    tick_1hz = tk; hour = h; min = m; sec = s; stop_key = stp; snooze_key = snz;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; stop_key = 1'b0; snooze_key = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, "/queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "/state"}, 32'(state_o), 32'(e.st));
      chk({tag, "/tone"},  32'(tone),    32'(e.tone));
      chk({tag, "/ring"},  32'(ring_on), 32'(e.ring));
    end
  endtask

  // A tick followed by a quiet cycle that must hold the same outputs
  task automatic tk(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                    input logic [1:0] es, input int et, input string tag);
    cyc(1'b1, h, m, s, 1'b0, 1'b0, es, et, tag);
    cyc(1'b0, h, m, s, 1'b0, 1'b0, es, et, {tag, "_hold"});
  endtask

  task automatic run_chime(input logic [5:0] h, input int n, input string tag);
    tk(h, 6'd0, 6'd0, S_CHIME, BEEP, {tag, "_b1"});
    for (int k = 1; k < 2 * n; k++)
      tk(h, 6'd0, 6'(k), S_CHIME, (k % 2 == 1) ? 0 : BEEP, $sformatf("%s_t%0d", tag, k));
    tk(h, 6'd0, 6'(2 * n), S_IDLE, 0, {tag, "_end"});
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_state", 32'(state_o), 32'(S_IDLE));
    chk("rst_tone",  32'(tone), 32'd0);
    chk("rst_ring",  32'(ring_on), 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // Alarm at 07:30: melody steps per tick, wraps, ends after 60 ticks
    alhour = 6'd7; almin = 6'd30; al_en = 1'b1;
    tk(6'd7, 6'd29, 6'd59, S_IDLE, 0, "pre_alarm");
    tk(6'd7, 6'd30, 6'd0, S_ALARM, mel[0], "alarm_entry");
    for (int i = 1; i < 60; i++)
      tk(6'd7, 6'd30, 6'(i), S_ALARM, mel[i % 19], $sformatf("ring%0d", i));
    tk(6'd7, 6'd31, 6'd0, S_IDLE, 0, "ring_done");

    // Hourly chimes with the alarm disarmed
    al_en = 1'b0;
    run_chime(6'd15, 3, "chime15");
    run_chime(6'd0, 12, "chime00");

    // Alarm at 12:00 beats the chime; stop+snooze together stop
    alhour = 6'd12; almin = 6'd0; al_en = 1'b1;
    tk(6'd12, 6'd0, 6'd0, S_ALARM, mel[0], "noon_alarm");
    tk(6'd12, 6'd0, 6'd1, S_ALARM, mel[1], "noon_ring1");
    cyc(1'b0, 6'd12, 6'd0, 6'd2, 1'b1, 1'b1, S_IDLE, 0, "stop_snooze");

    // Alarm preempts a chime, then disarming stops the ring
    alhour = 6'd2; almin = 6'd5;
    tk(6'd2, 6'd0, 6'd0, S_CHIME, BEEP, "chime2");
    tk(6'd2, 6'd0, 6'd1, S_CHIME, 0, "chime2_sil");
    tk(6'd2, 6'd5, 6'd0, S_ALARM, mel[0], "preempt");
    al_en = 1'b0;
    cyc(1'b0, 6'd2, 6'd5, 6'd1, 1'b0, 1'b0, S_IDLE, 0, "disarm");

    // Snooze at ring second 5
    alhour = 6'd7; almin = 6'd30; al_en = 1'b1;
    tk(6'd7, 6'd30, 6'd0, S_ALARM, mel[0], "snz_entry");
    for (int i = 1; i <= 5; i++)
      tk(6'd7, 6'd30, 6'(i), S_ALARM, mel[i], $sformatf("snz_ring%0d", i));
`ifdef ALARM_SNOOZE_EN
    cyc(1'b0, 6'd7, 6'd30, 6'd5, 1'b0, 1'b1, S_SNOOZE, 0, "snooze_key");
    for (int i = 1; i <= 300; i++)
      cyc(1'b1, 6'd7, 6'd40, 6'(i % 60), 1'b0, 1'b0, (i < 300) ? S_SNOOZE : S_ALARM,
          (i < 300) ? 0 : mel[0], $sformatf("snz%0d", i));
    tk(6'd7, 6'd41, 6'd1, S_ALARM, mel[1], "resnooze_ring1");
`else
    cyc(1'b0, 6'd7, 6'd30, 6'd5, 1'b0, 1'b1, S_ALARM, mel[5], "snooze_ignored");
    tk(6'd7, 6'd30, 6'd6, S_ALARM, mel[6], "ring_continues");
`endif
    cyc(1'b0, 6'd7, 6'd41, 6'd2, 1'b1, 1'b0, S_IDLE, 0, "stop");

    // Stop beats a trigger; no retrigger while ringing; async reset mid-ring
    cyc(1'b1, 6'd7, 6'd30, 6'd0, 1'b1, 1'b0, S_IDLE, 0, "stop_vs_trig");
    tk(6'd7, 6'd30, 6'd0, S_ALARM, mel[0], "g_entry");
    tk(6'd7, 6'd30, 6'd1, S_ALARM, mel[1], "g_ring1");
    tk(6'd7, 6'd30, 6'd0, S_ALARM, mel[2], "no_retrigger");
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state_o), 32'(S_IDLE));
    chk("async_rst_tone",  32'(tone), 32'd0);
    chk("async_rst_ring",  32'(ring_on), 32'd0);
    #2 rst_n = 1'b1;
    tk(6'd7, 6'd30, 6'd5, S_IDLE, 0, "post_rst_idle");
    tk(6'd7, 6'd30, 6'd0, S_ALARM, mel[0], "post_rst_trig");
    cyc(1'b0, 6'd7, 6'd30, 6'd1, 1'b1, 1'b0, S_IDLE, 0, "final_stop");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alarm_sched.md
ALARM_SCHED -- requirements
Module: alarm_sched

Interface
REQ-001 SHALL have parameter MEL_LEN, default 19: alarm melody length in notes.
REQ-002 SHALL have parameter RING_SECS, default 60: alarm duration in seconds.
REQ-003 SHALL have parameter SNOOZE_SECS, default 300: snooze wait in seconds.
REQ-004 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port tick_1hz, input, 1: one-cycle pulse, once per second.
REQ-007 SHALL have ports hour, min, sec, input, 6 each: current time, binary.
REQ-008 SHALL have ports alhour, almin, input, 6 each: alarm time.
REQ-009 SHALL have port al_en, input, 1: alarm armed.
REQ-010 SHALL have ports stop_key, snooze_key, input, 1 each: debounced one-cycle pulses.
REQ-011 SHALL have port tone, output, 20: registered tone period to the buzzer driver; 0 = silence.
REQ-012 SHALL have port ring_on, output, 1: high in CHIME or ALARM.
REQ-013 SHALL have port state_o, output, 2: current FSM state.

Function
REQ-014 SHALL implement FSM states IDLE=0, CHIME=1, ALARM=2, SNOOZE=3.
REQ-015 SHALL evaluate triggers only in cycles where tick_1hz=1.
REQ-016 Alarm trigger SHALL be al_en && hour==alhour && min==almin && sec==0; it enters ALARM from any state except ALARM.
REQ-017 Chime trigger SHALL be min==0 && sec==0 in IDLE; on a simultaneous alarm trigger, ALARM wins.
REQ-018 ALARM entry SHALL clear the note index and second counter; tone SHALL equal melody[0] on the cycle after entry.
REQ-019 In ALARM, each tick SHALL advance the note index, wrapping MEL_LEN-1 -> 0, and increment the second counter.
REQ-020 ALARM SHALL return to IDLE on the tick that brings the second counter to RING_SECS.
REQ-021 CHIME SHALL sound N beeps, N = hour mod 12, with 0 mapped to 12: each beep is one tick of NOTE_BEEP followed by one tick of silence; IDLE follows the last silence.
REQ-022 An alarm trigger during CHIME SHALL preempt it.
REQ-023 stop_key SHALL force IDLE from any state, with tone=0 on the next cycle.
REQ-024 stop_key SHALL win over a simultaneous snooze_key or trigger.
REQ-025 Deasserting al_en in ALARM or SNOOZE SHALL force IDLE on the next cycle.
REQ-026 tone SHALL be 0 in IDLE and SNOOZE; all outputs SHALL be registered with 1-cycle latency from the state change.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, tone=0, ring_on=0, and all counters and indices to 0; assertion mid-ring SHALL silence immediately.

Configuration
REQ-028 With ALARM_SNOOZE_EN defined, snooze_key in ALARM SHALL enter SNOOZE (counter cleared); after SNOOZE_SECS ticks the block SHALL re-enter ALARM at note 0 with the ring counter cleared.
REQ-029 Without ALARM_SNOOZE_EN, snooze_key SHALL be ignored, SNOOZE SHALL be unreachable, and SNOOZE_SECS SHALL be unused.

Structure
REQ-030 A shared package alarm_pkg SHALL hold the state enum, note period constants (113636, 127551, 143184, 151700, 170300, 191131, NOTE_BEEP=95556) and REST=0.
REQ-031 The melody table SHALL be a sub-module melody_rom (index in, 20-bit period out, combinational), reusable by other tone sources.

Verification
REQ-032 alhour=7, almin=30, al_en=1; tick at 07:30:00 -> state_o=2, ring_on=1, tone=melody[0] next cycle; tone steps once per tick; IDLE after 60 ticks.
REQ-033 Tick at 15:00:00, alarm disarmed -> exactly 3 beeps of 95556, each followed by one silent tick, then IDLE; at 00:00:00 -> 12 beeps.
REQ-034 Alarm set to 12:00 with tick at 12:00:00 -> ALARM, no chime beeps.
REQ-035 stop_key and snooze_key pulsed in the same cycle during ALARM -> IDLE, tone=0 next cycle.
REQ-036 ALARM_SNOOZE_EN defined: snooze at ring second 5 -> SNOOZE, tone=0; ALARM at note 0 after 300 ticks. Undefined: snooze ignored, ring continues.
REQ-037 rst_n pulsed low mid-ALARM between clock edges -> tone=0 and state_o=0 immediately; no trigger before the next matching tick.
